// File: rtl/ps2_cmd_pkg.sv
// Shared constants and state encoding for the PS/2 command scheduler.
package ps2_cmd_pkg;

    localparam logic [7:0] PS2_ACK           = 8'hFA;
    localparam logic [7:0] PS2_RESEND        = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK        = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL      = 8'hFC;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_CMD_ACK, SEND_ARG, WAIT_ARG_ACK, WAIT_BAT, DONE, ERR
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer advances past the winner on en_i.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
        any_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && any_o)
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Arbitrates command sources onto the PS/2 host transmit path and runs the
// command/ACK/argument/BAT handshake, forwarding non-protocol bytes to the scan path.
module ps2_cmd_scheduler
    import ps2_cmd_pkg::*;
#(
    parameter int NUM_REQ            = 3,
    parameter int TIMEOUT_CYCLES     = 1000000,
    parameter int BAT_TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRY          = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_cmd_i,
    input  logic [8*NUM_REQ-1:0] req_arg_i,
    input  logic [NUM_REQ-1:0]   req_has_arg_i,
    output logic [NUM_REQ-1:0]   req_grant_o,
    output logic [NUM_REQ-1:0]   req_done_o,
    output logic [NUM_REQ-1:0]   req_err_o,
    output logic [7:0]           host_tx_data_o,
    output logic                 host_tx_req_o,
    input  logic                 host_tx_ready_i,
    input  logic [7:0]           host_rx_data_i,
    input  logic                 host_rx_ready_i,
    output logic [7:0]           scan_data_o,
    output logic                 scan_valid_o,
    output logic                 busy_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(max_int(TIMEOUT_CYCLES, BAT_TIMEOUT_CYCLES)) + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    sched_state_t       state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         cmd_q, cmd_d, arg_q, arg_d;
    logic               has_arg_q, has_arg_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               tx_req_q, tx_req_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               scan_valid_q, scan_valid_d;
    logic [7:0]         scan_data_q, scan_data_d;

    logic               arb_en, arb_any;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req_valid_i),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    logic rx_ack, rx_resend, rx_bat_ok, rx_bat_fail, expired, consumed;

    assign rx_ack      = host_rx_ready_i && (host_rx_data_i == PS2_ACK);
    assign rx_resend   = host_rx_ready_i && (host_rx_data_i == PS2_RESEND);
    assign rx_bat_ok   = host_rx_ready_i && (host_rx_data_i == PS2_BAT_OK);
    assign rx_bat_fail = host_rx_ready_i && (host_rx_data_i == PS2_BAT_FAIL);
    // Timer counts down each wait cycle; the cycle whose decrement lands on zero expires.
    assign expired     = (timer_q <= TW'(1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        has_arg_d    = has_arg_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        grant_d      = '0;
        tx_req_d     = 1'b0;
        tx_data_d    = tx_data_q;
        scan_valid_d = 1'b0;
        scan_data_d  = scan_data_q;
        arb_en       = 1'b0;
        consumed     = 1'b0;

        if (state_q == WAIT_CMD_ACK || state_q == WAIT_ARG_ACK || state_q == WAIT_BAT)
            if (timer_q != '0) timer_d = timer_q - 1'b1;

        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (arb_any) begin
                    grant_d   = arb_gnt;
                    idx_d     = arb_idx;
                    cmd_d     = req_cmd_i[arb_idx*8 +: 8];
                    arg_d     = req_arg_i[arb_idx*8 +: 8];
                    has_arg_d = req_has_arg_i[arb_idx];
                    state_d   = SEND_CMD;
                end
            end
            SEND_CMD, SEND_ARG: begin
                if (host_tx_ready_i) begin
                    tx_req_d  = 1'b1;
                    tx_data_d = (state_q == SEND_CMD) ? cmd_q : arg_q;
                    timer_d   = TW'(TIMEOUT_CYCLES);
                    state_d   = (state_q == SEND_CMD) ? WAIT_CMD_ACK : WAIT_ARG_ACK;
                end
            end
            WAIT_CMD_ACK, WAIT_ARG_ACK: begin
                if (rx_ack) begin
                    consumed = 1'b1;
                    if (state_q == WAIT_ARG_ACK)   state_d = DONE;
                    else if (has_arg_q)            state_d = SEND_ARG;
                    else if (cmd_q == PS2_CMD_RESET) begin
                        state_d = WAIT_BAT;
                        timer_d = TW'(BAT_TIMEOUT_CYCLES);
                    end else                       state_d = DONE;
                end else if (rx_resend) begin
                    consumed = 1'b1;
                    retry_d  = retry_q + 1'b1;
                    if (retry_q >= RW'(MAX_RETRY)) state_d = ERR;
                    else state_d = (state_q == WAIT_CMD_ACK) ? SEND_CMD : SEND_ARG;
                end else if (!host_rx_ready_i && expired) begin
                    state_d = ERR;
                end
            end
            WAIT_BAT: begin
                if (rx_bat_ok) begin
                    consumed = 1'b1;
                    state_d  = DONE;
                end else if (rx_bat_fail) begin
                    consumed = 1'b1;
                    state_d  = ERR;
                end else if (!host_rx_ready_i && expired) begin
                    state_d = ERR;
                end
            end
            DONE, ERR: begin
                retry_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (host_rx_ready_i && !consumed) begin
            scan_valid_d = 1'b1;
            scan_data_d  = host_rx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cmd_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            retry_q      <= '0;
            timer_q      <= '0;
            grant_q      <= '0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            has_arg_q    <= has_arg_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            tx_req_q     <= tx_req_d;
            tx_data_q    <= tx_data_d;
            scan_valid_q <= scan_valid_d;
            scan_data_q  <= scan_data_d;
        end
    end

    always_comb begin
        req_done_o = '0;
        req_err_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_done_o[i] = (state_q == DONE) && (idx_q == IW'(i));
            req_err_o[i]  = (state_q == ERR)  && (idx_q == IW'(i));
        end
    end

    assign req_grant_o    = grant_q;
    assign host_tx_req_o  = tx_req_q;
    assign host_tx_data_o = tx_data_q;
    assign scan_valid_o   = scan_valid_q;
    assign scan_data_o    = scan_data_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
Shares the single PS/2 host transmit path among several command sources, e.g. init/reset, LED indicators and typematic configuration. Runs the full PS/2 command protocol for each granted request: command byte, ACK, optional argument byte, ACK, and BAT completion for reset. Handles resend, retry and timeout. Sits between the requesters and ps2_host, and forwards every non-protocol receive byte to the scan-code decoder.

Parameters:
NUM_REQ, 3, number of requesters; index 0 is the init/reset source
TIMEOUT_CYCLES, 1000000, ACK wait limit in clk cycles (20 ms at 50 MHz)
BAT_TIMEOUT_CYCLES, 50000000, BAT wait limit after reset ACK (1 s)
MAX_RETRY, 3, resend (0xFE) retries allowed per transaction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  request pending; held until req_grant
req_cmd  in  8*NUM_REQ  command byte per requester
req_arg  in  8*NUM_REQ  argument byte per requester
req_has_arg  in  NUM_REQ  command carries an argument byte
req_grant  out  NUM_REQ  1-cycle pulse; request latched
req_done  out  NUM_REQ  1-cycle pulse; success
req_err  out  NUM_REQ  1-cycle pulse; timeout, retry exhaustion or BAT fail
host_tx_data  out  8  byte to ps2_host
host_tx_req  out  1  1-cycle send strobe
host_tx_ready  in  1  host idle, can accept a byte
host_rx_data  in  8  received byte, valid with host_rx_ready
host_rx_ready  in  1  1-cycle receive pulse
scan_data  out  8  forwarded byte
scan_valid  out  1  1-cycle pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; retry and timer counters 0. A reset applied mid-transaction abandons it and pulses no done or err.
- Arbitration, IDLE only: round-robin starting at the pointer. Grant pulse on the same cycle cmd, arg and has_arg are latched. Pointer moves to winner+1 mod NUM_REQ. Move to SEND_CMD next cycle.
- SEND_CMD / SEND_ARG: wait for host_tx_ready=1. Then host_tx_req=1 for exactly one cycle, with host_tx_data holding the byte from that cycle until the next send. Load the timer and move to WAIT_CMD_ACK or WAIT_ARG_ACK.
- WAIT_CMD_ACK, on rx byte:
  - 0xFA: go to SEND_ARG if has_arg; else WAIT_BAT if cmd==0xFF; else DONE.
  - 0xFE: increment retry; if retry>MAX_RETRY go to ERR, else go to SEND_CMD.
  - Any other byte: forward to the scan path and keep waiting; the timer is not reloaded.
- WAIT_ARG_ACK: same rules as WAIT_CMD_ACK, but 0xFE resends the argument (go to SEND_ARG) and 0xFA goes to DONE.
- WAIT_BAT, using BAT_TIMEOUT_CYCLES: 0xAA goes to DONE, 0xFC goes to ERR, any other byte is forwarded.
- Timer expiry (counter reaches 0) in any WAIT state goes to ERR. If a byte arrives in the expiry cycle, the byte wins.
- DONE / ERR: one cycle; pulse req_done or req_err on the latched index, clear retry, go to IDLE. A new grant is possible on the following cycle.
- Scan path: in IDLE, SEND_* and for unconsumed bytes, scan_data=host_rx_data and scan_valid=1 on the cycle after host_rx_ready (1-cycle latency). Protocol bytes consumed by a WAIT state are never forwarded.
- Retry counter is per transaction, shared by the cmd and arg bytes. Timer width is $clog2(max timeout)+1.

Decomposition:
- ps2_cmd_pkg holds:
  - constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_BAT_OK=8'hAA, PS2_BAT_FAIL=8'hFC, PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_TYPEMATIC=8'hF3
  - enum sched_state_t {IDLE, SEND_CMD, WAIT_CMD_ACK, SEND_ARG, WAIT_ARG_ACK, WAIT_BAT, DONE, ERR}
- Sub-module rr_arbiter: req vector in; one-hot grant and index out; pointer update on an enable input.

Test Plan:
- Requester 1 sends 0xED/arg 0x04; model ACKs both bytes -> tx sequence ED,04; req_grant[1] then req_done[1]; busy low afterwards; no scan_valid.
- Requester 0 sends 0xFF with no arg; model ACKs 0xFA then 0xAA -> req_done[0]. Repeat with 0xFC instead of 0xAA -> req_err[0].
- Requester 2 sends F3/20; model answers the argument with FE twice, then FA -> tx sequence F3,20,20,20; req_done[2]. With 4 FEs -> req_err[2] after the 4th, no further tx.
- req_valid=3'b111 held continuously -> grants in order 0,1,2,0,…; no grant while busy.
- Scan byte 0x1C arrives during WAIT_CMD_ACK, then FA -> scan_data=1C forwarded; command completes. With no response -> req_err exactly TIMEOUT_CYCLES after the tx strobe (use a reduced parameter).
- Reset asserted during WAIT_ARG_ACK -> all outputs 0 next cycle, state IDLE, no done/err pulse, pointer 0.
